// File: rtl/rc_pkg.sv
// Shared definitions for the RISC controller: opcodes, phase numbers,
// the control-strobe bundle and the ALU-operation decode helper.
package rc_pkg;

  // Instruction-register opcodes
  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  // Instruction-cycle phases
  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  // All control outputs grouped so the decoder can default them in one go
  typedef struct packed {
    logic sel;
    logic rd;
    logic wr;
    logic ld_ir;
    logic ld_ac;
    logic ld_pc;
    logic inc_pc;
    logic data_e;
    logic halt;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Opcodes whose result comes from a memory operand through the ALU
  function automatic logic isALUOP(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/rc_phase_counter.sv
// Wrapping phase counter: advances by one when advance_i is set,
// holds otherwise, and returns to zero on a synchronous active-low reset.
module rc_phase_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         advance_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: natural wrap of the W-bit adder gives max -> 0 with no idle cycle
  always_comb begin
    count_d = count_q;
    if (advance_i) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register with reset taking priority over advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/risc_controller.sv
// Eight-phase RISC CPU sequencer: a phase counter plus a halted flag,
// with all control strobes decoded combinationally from phase, opcode and zero.
module risc_controller
  import rc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       wr,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  logic       halted_q;
  logic       halted_d;
  logic       halt_req;
  logic       advance;
  logic [2:0] phase_q;
  ctrl_t      ctrl;

  // A HLT seen in OP_ADDR freezes the phase there instead of moving on
  assign halt_req = (phase_q == PH_OP_ADDR) && (opcode == OP_HLT);
  assign advance  = ena && !halted_q && !halt_req;

  rc_phase_counter #(
    .W(3)
  ) u_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance_i(advance),
    .count_o  (phase_q)
  );

  // Halted flag is sticky: only reset clears it
  always_comb begin
    halted_d = halted_q;
    if (ena && halt_req) begin
      halted_d = 1'b1;
    end
  end

  // Halted flag register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  // Strobe decode; opcode and zero only matter from OP_ADDR onwards
  always_comb begin
    ctrl = CTRL_NONE;
    unique case (phase_q)
      PH_INST_ADDR: begin
        ctrl.sel = 1'b1;
      end
      PH_INST_FETCH: begin
        ctrl.sel = 1'b1;
        ctrl.rd  = 1'b1;
      end
      PH_INST_LOAD, PH_IDLE: begin
        ctrl.sel   = 1'b1;
        ctrl.rd    = 1'b1;
        ctrl.ld_ir = 1'b1;
      end
      PH_OP_ADDR: begin
        ctrl.inc_pc = 1'b1;
        ctrl.halt   = (opcode == OP_HLT);
      end
      PH_OP_FETCH: begin
        ctrl.rd = isALUOP(opcode);
      end
      PH_ALU_OP: begin
        ctrl.rd     = isALUOP(opcode);
        ctrl.inc_pc = (opcode == OP_SKZ) && zero;
        ctrl.ld_pc  = (opcode == OP_JMP);
        ctrl.data_e = (opcode == OP_STO);
      end
      PH_STORE: begin
        ctrl.rd     = isALUOP(opcode);
        ctrl.ld_ac  = isALUOP(opcode);
        ctrl.inc_pc = (opcode == OP_JMP);
        ctrl.ld_pc  = (opcode == OP_JMP);
        ctrl.wr     = (opcode == OP_STO);
        ctrl.data_e = (opcode == OP_STO);
      end
      default: begin
        ctrl = CTRL_NONE;
      end
    endcase
    // Once halted, only the halt indication remains
    if (halted_q) begin
      ctrl      = CTRL_NONE;
      ctrl.halt = 1'b1;
    end
  end

  assign sel    = ctrl.sel;
  assign rd     = ctrl.rd;
  assign wr     = ctrl.wr;
  assign ld_ir  = ctrl.ld_ir;
  assign ld_ac  = ctrl.ld_ac;
  assign ld_pc  = ctrl.ld_pc;
  assign inc_pc = ctrl.inc_pc;
  assign data_e = ctrl.data_e;
  assign halt   = ctrl.halt;
  assign phase  = phase_q;

endmodule

// File: tb/tb_risc_controller.sv
// Self-checking bench for risc_controller: a table of per-cycle vectors
// plus hand-written halt and stretch/reset sequences, checked through a
// scoreboard queue.
module tb_risc_controller;

  // Opcode values
  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] SKZ = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] LDA = 3'b101;
  localparam logic [2:0] STO = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  // Output bit masks in the order {sel,rd,wr,ld_ir,ld_ac,ld_pc,inc_pc,data_e,halt}
  localparam logic [8:0] S = 9'h100;
  localparam logic [8:0] R = 9'h080;
  localparam logic [8:0] W = 9'h040;
  localparam logic [8:0] I = 9'h020;
  localparam logic [8:0] A = 9'h010;
  localparam logic [8:0] P = 9'h008;
  localparam logic [8:0] N = 9'h004;
  localparam logic [8:0] D = 9'h002;
  localparam logic [8:0] H = 9'h001;
  localparam logic [8:0] Z = 9'h000;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
  logic [2:0] phase;

  risc_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .opcode(opcode),
    .zero  (zero),
    .sel   (sel),
    .rd    (rd),
    .wr    (wr),
    .ld_ir (ld_ir),
    .ld_ac (ld_ac),
    .ld_pc (ld_pc),
    .inc_pc(inc_pc),
    .data_e(data_e),
    .halt  (halt),
    .phase (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       ena;
    logic [2:0] op;
    logic       zero;
    logic       chk;
    logic [2:0] ph;
    logic [8:0] outs;
  } vec_t;

  typedef struct {
    int         idx;
    logic [2:0] ph;
    logic [8:0] outs;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   seq   = 0;

  function automatic void add(input logic r, input logic e, input logic [2:0] op,
                              input logic z, input logic [2:0] ph, input logic [8:0] o);
    vec_t v;
    v.rst_n = r; v.ena = e; v.op = op; v.zero = z; v.chk = 1'b1; v.ph = ph; v.outs = o;
    vecs.push_back(v);
  endfunction

  // Instruction fetch phases 0..3; the opcode/zero given here must have no effect
  function automatic void add_fetch(input logic [2:0] op, input logic z);
    add(1, 1, op, z, 3'd0, S);
    add(1, 1, op, z, 3'd1, S | R);
    add(1, 1, op, z, 3'd2, S | R | I);
    add(1, 1, op, z, 3'd3, S | R | I);
  endfunction

  // One cycle: drive inputs after the edge, record expectation, sample mid-cycle
  task automatic step(input logic r, input logic e, input logic [2:0] op, input logic z,
                      input logic chk, input logic [2:0] ph, input logic [8:0] o);
    exp_t x;
    exp_t got;
    logic [8:0] act;
    @(posedge clk);
    #1;
    rst_n  = r;
    ena    = e;
    opcode = op;
    zero   = z;
    if (chk) begin
      x.idx = seq; x.ph = ph; x.outs = o;
      sb.push_back(x);
    end
    #3;
    act = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt};
    if (chk) begin
      got = sb.pop_front();
      total++;
      if (phase !== got.ph || act !== got.outs) begin
        bad++;
        $display("FAIL step%0d op=%0d phase=%0d outs=%h required phase=%0d outs=%h",
                 got.idx, op, phase, act, got.ph, got.outs);
      end else begin
        $display("ok   step%0d op=%0d phase=%0d outs=%h", got.idx, op, phase, act);
      end
      total++;
      if ((rd & wr) !== 1'b0) begin
        bad++;
        $display("FAIL rd_wr_excl step%0d rd=%b wr=%b required not both 1", got.idx, rd, wr);
      end
    end
    seq++;
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b0;
    opcode = ADD;
    zero   = 1'b0;

    // ---------------- table of full instruction cycles ----------------
    begin
      vec_t v;
      v.rst_n = 0; v.ena = 1; v.op = ADD; v.zero = 0; v.chk = 0; v.ph = 0; v.outs = Z;
      vecs.push_back(v);
    end
    // ADD, with HLT on the opcode lines during fetch
    add_fetch(HLT, 1);
    add(1, 1, ADD, 0, 3'd4, N);
    add(1, 1, ADD, 1, 3'd5, R);
    add(1, 1, ADD, 1, 3'd6, R);
    add(1, 1, ADD, 0, 3'd7, R | A);
    // SKZ with zero=1
    add_fetch(JMP, 0);
    add(1, 1, SKZ, 1, 3'd4, N);
    add(1, 1, SKZ, 1, 3'd5, Z);
    add(1, 1, SKZ, 1, 3'd6, N);
    add(1, 1, SKZ, 1, 3'd7, Z);
    // SKZ with zero=0
    add_fetch(ADD, 1);
    add(1, 1, SKZ, 0, 3'd4, N);
    add(1, 1, SKZ, 0, 3'd5, Z);
    add(1, 1, SKZ, 0, 3'd6, Z);
    add(1, 1, SKZ, 0, 3'd7, Z);
    // STO
    add_fetch(STO, 0);
    add(1, 1, STO, 0, 3'd4, N);
    add(1, 1, STO, 1, 3'd5, Z);
    add(1, 1, STO, 0, 3'd6, D);
    add(1, 1, STO, 0, 3'd7, W | D);
    // JMP, zero=1 must not add an SKZ increment
    add_fetch(SKZ, 1);
    add(1, 1, JMP, 1, 3'd4, N);
    add(1, 1, JMP, 1, 3'd5, Z);
    add(1, 1, JMP, 1, 3'd6, P);
    add(1, 1, JMP, 1, 3'd7, N | P);
    // Remaining ALU operations
    add_fetch(XOR, 0);
    add(1, 1, AND, 0, 3'd4, N);
    add(1, 1, AND, 0, 3'd5, R);
    add(1, 1, AND, 0, 3'd6, R);
    add(1, 1, AND, 0, 3'd7, R | A);
    add_fetch(LDA, 0);
    add(1, 1, XOR, 1, 3'd4, N);
    add(1, 1, XOR, 1, 3'd5, R);
    add(1, 1, XOR, 1, 3'd6, R);
    add(1, 1, XOR, 1, 3'd7, R | A);
    add_fetch(HLT, 0);
    add(1, 1, LDA, 0, 3'd4, N);
    add(1, 1, LDA, 0, 3'd5, R);
    add(1, 1, LDA, 0, 3'd6, R);
    add(1, 1, LDA, 0, 3'd7, R | A);
    // Wrap straight back to INST_ADDR
    add(1, 1, ADD, 0, 3'd0, S);

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].rst_n, vecs[k].ena, vecs[k].op, vecs[k].zero,
           vecs[k].chk, vecs[k].ph, vecs[k].outs);
    end

    // ---------------- halt sequence ----------------
    step(0, 1, ADD, 0, 0, 3'd0, Z);
    step(1, 1, HLT, 0, 1, 3'd0, S);
    step(1, 1, HLT, 0, 1, 3'd1, S | R);
    step(1, 1, HLT, 0, 1, 3'd2, S | R | I);
    step(1, 1, HLT, 0, 1, 3'd3, S | R | I);
    step(1, 0, HLT, 0, 1, 3'd4, N | H);   // ena=0: not yet halted
    step(1, 1, HLT, 0, 1, 3'd4, N | H);   // this edge sets halted
    for (int k = 0; k < 20; k++) begin
      step(1, 1, (k % 2 == 0) ? HLT : ADD, k[0], 1, 3'd4, H);
    end
    step(0, 1, ADD, 0, 1, 3'd4, H);       // reset applied at the following edge
    step(1, 0, ADD, 0, 1, 3'd0, S);
    step(1, 0, ADD, 0, 1, 3'd0, S);

    // ---------------- stretch and mid-instruction reset ----------------
    step(1, 1, ADD, 0, 1, 3'd0, S);
    step(1, 1, ADD, 0, 1, 3'd1, S | R);
    step(1, 0, ADD, 0, 1, 3'd2, S | R | I);
    step(1, 0, ADD, 0, 1, 3'd2, S | R | I);
    step(1, 0, ADD, 0, 1, 3'd2, S | R | I);
    step(1, 1, ADD, 0, 1, 3'd2, S | R | I);
    step(1, 1, ADD, 0, 1, 3'd3, S | R | I);
    step(1, 1, ADD, 0, 1, 3'd4, N);
    step(1, 1, ADD, 0, 1, 3'd5, R);
    step(0, 1, ADD, 0, 1, 3'd6, R);       // reset wins over ena at the next edge
    step(1, 1, ADD, 0, 1, 3'd0, S);
    step(1, 1, ADD, 0, 1, 3'd1, S | R);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d required 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
